rat_commit_ctrl: RTL

RAT_COMMIT_CTRL -- requirements
Module: rat_commit_ctrl

---
 rtl/rat_commit_ctrl.sv | 126 ++++++++++++
 1 files changed

// File: rtl/rat_commit_ctrl.sv
// In-order retirement controller: pops the ROB head, issues one registered ARF write per
// cycle, and on a mispredicted head emits a flush/redirect pulse then stalls dispatch.
// Optional performance counters are enabled by defining COMMIT_PERF_CNT_EN.
module rat_commit_ctrl #(
    parameter int FLUSH_CYCLES  = 2,
    parameter int ROB_IDX_WIDTH = 5
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     rob_head_valid,
    input  logic [ROB_IDX_WIDTH-1:0] rob_head_idx,
    input  logic [4:0]               rob_head_rd_addr,
    input  logic                     rob_head_regf_we,
    input  logic [31:0]              rob_head_data,
    input  logic                     rob_head_mispredict,
    input  logic [31:0]              rob_head_target,
    output logic                     rob_dequeue,
    output logic                     commit_we,
    output logic [4:0]               commit_rd_addr,
    output logic [31:0]              commit_data,
    output logic [ROB_IDX_WIDTH-1:0] commit_rob_idx,
    output logic                     flush,
    output logic                     redirect_valid,
    output logic [31:0]              redirect_pc,
    output logic                     dispatch_stall
`ifdef COMMIT_PERF_CNT_EN
    ,
    output logic [31:0]              retire_count,
    output logic [15:0]              flush_count
`endif
);

    typedef enum logic {RUN, FLUSH} state_t;

    state_t     state, state_next;
    logic [3:0] flush_cnt, flush_cnt_next;
    logic       retire;
    logic       redirect_take;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= RUN;
            flush_cnt <= 4'd0;
        end else begin
            state     <= state_next;
            flush_cnt <= flush_cnt_next;
        end
    end

    always_comb begin
        state_next     = state;
        flush_cnt_next = flush_cnt;
        rob_dequeue    = 1'b0;
        dispatch_stall = 1'b0;
        retire         = 1'b0;
        redirect_take  = 1'b0;
        case (state)
            RUN: begin
                rob_dequeue = rob_head_valid & ~rst;
                retire      = rob_dequeue;
                if (retire && rob_head_mispredict) begin
                    redirect_take  = 1'b1;
                    state_next     = FLUSH;
                    flush_cnt_next = 4'(FLUSH_CYCLES);
                end
            end
            FLUSH: begin
                dispatch_stall = 1'b1;
                // Leave once the counter has been observed at 1 (or lower, defensively).
                if (flush_cnt <= 4'd1) begin
                    state_next     = RUN;
                    flush_cnt_next = 4'd0;
                end else begin
                    flush_cnt_next = 4'(flush_cnt - 4'd1);
                end
            end
            default: begin
                state_next     = RUN;
                flush_cnt_next = 4'd0;
            end
        endcase
    end

    // ---- commit / redirect register stage ----
    always_ff @(posedge clk) begin
        if (rst) begin
            commit_we      <= 1'b0;
            commit_rd_addr <= 5'd0;
            commit_data    <= 32'd0;
            commit_rob_idx <= '0;
            flush          <= 1'b0;
            redirect_valid <= 1'b0;
            redirect_pc    <= 32'd0;
        end else begin
            // x0 writes are suppressed but the entry still retires.
            commit_we      <= retire & rob_head_regf_we & (|rob_head_rd_addr);
            flush          <= redirect_take;
            redirect_valid <= redirect_take;
            if (retire) begin
                commit_rd_addr <= rob_head_rd_addr;
                commit_data    <= rob_head_data;
                commit_rob_idx <= rob_head_idx;
            end
            if (redirect_take) begin
                redirect_pc <= rob_head_target;
            end
        end
    end

`ifdef COMMIT_PERF_CNT_EN
    always_ff @(posedge clk) begin
        if (rst) begin
            retire_count <= 32'd0;
            flush_count  <= 16'd0;
        end else begin
            if (retire) begin
                retire_count <= retire_count + 32'd1;
            end
            if (redirect_take) begin
                flush_count <= flush_count + 16'd1;
            end
        end
    end
`endif

endmodule
